csr_timer_bank: RTL and testbench

//  Parametrised LoongArch constant-timer bank for the CSR unit: NUM_TIMERS independent TCFG/TVAL/TICLR channels.

---
 rtl/csr_timer_bank_pkg.sv | 25 ++
 rtl/csr_timer_chan.sv | 84 ++++++++
 rtl/csr_timer_bank.sv | 96 +++++++++
 tb/tb_csr_timer_bank.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_timer_bank_pkg.sv
// Shared definitions for the constant-timer bank: register selects,
// TCFG field positions and the masked-write merge helper.
package csr_timer_bank_pkg;

    // Register select encoding on csr_wreg / csr_rreg (value 3 is reserved)
    typedef enum logic [1:0] {
        TMR_TCFG  = 2'd0,
        TMR_TVAL  = 2'd1,
        TMR_TICLR = 2'd2
    } timer_reg_e;

    localparam int TCFG_EN       = 0;
    localparam int TCFG_PERIODIC = 1;
    localparam int TCFG_INIT_LSB = 2;

    // csrwr uses an all-ones mask, csrxchg uses rj as the mask
    function automatic logic [31:0] masked_merge(
        input logic [31:0] old_v,
        input logic [31:0] wdata,
        input logic [31:0] wmask
    );
        return (old_v & ~wmask) | (wdata & wmask);
    endfunction

endpackage

// File: rtl/csr_timer_chan.sv
// One constant-timer channel: TCFG, TVAL countdown and the sticky pending bit.
// Write strobes arrive already decoded from the bank's write port.
module csr_timer_chan
    import csr_timer_bank_pkg::*;
#(
    parameter int TIMESIZE = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we_tcfg,
    input  logic        we_ticlr,
    input  logic [31:0] wdata,
    input  logic [31:0] wmask,
    output logic [31:0] tcfg_val,
    output logic [31:0] tval_val,
    output logic        pending
);

    localparam logic [TIMESIZE-1:0] ONE_C = TIMESIZE'(1);

    logic [TIMESIZE-1:0] tcfg_r;
    logic [TIMESIZE-1:0] tval_r;
    logic                pending_r;

    logic [31:0]         tcfg_ext_s;
    logic [31:0]         merged_s;
    logic [TIMESIZE-1:0] new_tcfg_s;
    logic [TIMESIZE-1:0] reload_s;
    logic [TIMESIZE-1:0] new_reload_s;
    logic                running_s;
    logic                expire_s;

    // Zero-extend TCFG so bits above TIMESIZE read as zero and cannot be written
    always_comb begin
        tcfg_ext_s                 = 32'd0;
        tcfg_ext_s[TIMESIZE-1:0]   = tcfg_r;
        tval_val                   = 32'd0;
        tval_val[TIMESIZE-1:0]     = tval_r;
    end

    assign tcfg_val     = tcfg_ext_s;
    assign merged_s     = masked_merge(tcfg_ext_s, wdata, wmask);
    assign new_tcfg_s   = merged_s[TIMESIZE-1:0];
    assign reload_s     = {tcfg_r[TIMESIZE-1:TCFG_INIT_LSB], 2'b00};
    assign new_reload_s = {new_tcfg_s[TIMESIZE-1:TCFG_INIT_LSB], 2'b00};

    // A zero TVAL never counts, so a zero reload value can never fire
    assign running_s = tcfg_r[TCFG_EN] && (tval_r != '0);
    assign expire_s  = tcfg_r[TCFG_EN] && (tval_r == ONE_C) && !we_tcfg;
    assign pending   = pending_r;

    // TCFG/TVAL update: a TCFG write reloads TVAL and overrides any countdown
    always_ff @(posedge clk) begin
        if (reset) begin
            tcfg_r <= '0;
            tval_r <= '0;
        end else if (we_tcfg) begin
            tcfg_r <= new_tcfg_s;
            tval_r <= new_reload_s;
        end else if (running_s) begin
            if (tval_r == ONE_C) begin
                tval_r <= tcfg_r[TCFG_PERIODIC] ? reload_s : '0;
            end else begin
                tval_r <= tval_r - ONE_C;
            end
        end else begin
            tval_r <= tval_r;
        end
    end

    // Sticky pending: an expiry in the same cycle as a clear wins so no interrupt is lost
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_r <= 1'b0;
        end else if (expire_s) begin
            pending_r <= 1'b1;
        end else if (we_ticlr) begin
            pending_r <= 1'b0;
        end else begin
            pending_r <= pending_r;
        end
    end

endmodule

// File: rtl/csr_timer_bank.sv
// LoongArch constant-timer bank for the CSR unit: NUM_TIMERS timer channels,
// the CSR write decode / read mux, and the free-running stable counter.
module csr_timer_bank
    import csr_timer_bank_pkg::*;
#(
    parameter int NUM_TIMERS = 2,
    parameter int TIMESIZE   = 32,
    parameter int CNT_W      = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  csr_we,
    input  logic [2:0]            csr_wch,
    input  logic [1:0]            csr_wreg,
    input  logic [31:0]           csr_wdata,
    input  logic [31:0]           csr_wmask,
    input  logic [2:0]            csr_rch,
    input  logic [1:0]            csr_rreg,
    output logic [31:0]           csr_rdata,
    output logic [31:0]           counter_hi,
    output logic [31:0]           counter_lo,
    output logic [NUM_TIMERS-1:0] ti_pending,
    output logic                  ti_irq
);

    localparam logic [CNT_W-1:0] CNT_ONE_C = CNT_W'(1);

    // All eight channel slots exist so a 3-bit index always hits a defined
    // entry; slots beyond NUM_TIMERS are tied to zero.
    logic [31:0] tcfg_s [8];
    logic [31:0] tval_s [8];
    logic [7:0]  pend_all_s;
    logic [7:0]  we_tcfg_s;
    logic [7:0]  we_ticlr_s;
    logic        clr_bit_s;
    logic [31:0] rdata_s;
    logic [CNT_W-1:0] cnt_r;

    assign clr_bit_s = csr_wdata[0] & csr_wmask[0];

    for (genvar g = 0; g < 8; g++) begin : g_chan
        assign we_tcfg_s[g]  = csr_we && (csr_wch == 3'(g)) && (csr_wreg == TMR_TCFG);
        assign we_ticlr_s[g] = csr_we && (csr_wch == 3'(g)) && (csr_wreg == TMR_TICLR) && clr_bit_s;

        if (g < NUM_TIMERS) begin : g_live
            csr_timer_chan #(
                .TIMESIZE (TIMESIZE)
            ) u_chan (
                .clk      (clk),
                .reset    (reset),
                .we_tcfg  (we_tcfg_s[g]),
                .we_ticlr (we_ticlr_s[g]),
                .wdata    (csr_wdata),
                .wmask    (csr_wmask),
                .tcfg_val (tcfg_s[g]),
                .tval_val (tval_s[g]),
                .pending  (pend_all_s[g])
            );
        end else begin : g_absent
            assign tcfg_s[g]     = 32'd0;
            assign tval_s[g]     = 32'd0;
            assign pend_all_s[g] = 1'b0;
        end
    end

    // Read mux: TICLR and the reserved select read as zero
    always_comb begin
        rdata_s = 32'd0;
        case (csr_rreg)
            TMR_TCFG: rdata_s = tcfg_s[csr_rch];
            TMR_TVAL: rdata_s = tval_s[csr_rch];
            default:  rdata_s = 32'd0;
        endcase
    end

    assign csr_rdata  = rdata_s;
    assign ti_pending = pend_all_s[NUM_TIMERS-1:0];
    assign ti_irq     = |pend_all_s;

    // Stable counter: counts every cycle regardless of pipeline state, wraps silently
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_ONE_C;
        end
    end

    // Split the stable counter into the two rdcnt halves, high half zero-extended
    always_comb begin
        counter_hi              = 32'd0;
        counter_hi[CNT_W-33:0]  = cnt_r[CNT_W-1:32];
        counter_lo              = cnt_r[31:0];
    end

endmodule

// File: tb/tb_csr_timer_bank.sv
// Directed bench for csr_timer_bank: expected values go into a scoreboard
// queue as each step is driven and are popped when the DUT output is sampled.
module tb_csr_timer_bank;
    import csr_timer_bank_pkg::*;

    localparam int NT = 2;
    localparam int CW = 34;

    logic          clk = 1'b0;
    logic          reset;
    logic          csr_we;
    logic [2:0]    csr_wch;
    logic [1:0]    csr_wreg;
    logic [31:0]   csr_wdata;
    logic [31:0]   csr_wmask;
    logic [2:0]    csr_rch;
    logic [1:0]    csr_rreg;
    logic [31:0]   csr_rdata;
    logic [31:0]   counter_hi;
    logic [31:0]   counter_lo;
    logic [NT-1:0] ti_pending;
    logic          ti_irq;

    int vectors     = 0;
    int miscompares = 0;

    string       tag_q[$];
    logic [31:0] exp_q[$];

    // Long period so many reads fit inside the low phase of one cycle
    always #50 clk = ~clk;

    csr_timer_bank #(
        .NUM_TIMERS (NT),
        .TIMESIZE   (32),
        .CNT_W      (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .csr_we     (csr_we),
        .csr_wch    (csr_wch),
        .csr_wreg   (csr_wreg),
        .csr_wdata  (csr_wdata),
        .csr_wmask  (csr_wmask),
        .csr_rch    (csr_rch),
        .csr_rreg   (csr_rreg),
        .csr_rdata  (csr_rdata),
        .counter_hi (counter_hi),
        .counter_lo (counter_lo),
        .ti_pending (ti_pending),
        .ti_irq     (ti_irq)
    );

    task automatic expect_val(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic compare_next(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL scoreboard_empty: observed %h expected <entry>", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            vectors++;
            assert (obs === e) else begin
                miscompares++;
                $error("FAIL %s: observed %h expected %h", t, obs, e);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] v);
        expect_val(tag, v);
        compare_next(obs);
    endtask

    task automatic rd(input string tag, input logic [2:0] ch, input logic [1:0] rg, input logic [31:0] v);
        expect_val(tag, v);
        csr_rch  = ch;
        csr_rreg = rg;
        #1;
        compare_next(csr_rdata);
    endtask

    task automatic pend(input string tag, input logic [NT-1:0] v);
        expect_val(tag, 32'(v));
        #1;
        compare_next(32'(ti_pending));
    endtask

    task automatic wr(input logic [2:0] ch, input logic [1:0] rg, input logic [31:0] d, input logic [31:0] m);
        csr_we    = 1'b1;
        csr_wch   = ch;
        csr_wreg  = rg;
        csr_wdata = d;
        csr_wmask = m;
        @(negedge clk);
        csr_we    = 1'b0;
        csr_wdata = 32'd0;
        csr_wmask = 32'd0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Directed sequence
    initial begin
        reset     = 1'b1;
        csr_we    = 1'b0;
        csr_wch   = 3'd0;
        csr_wreg  = 2'd0;
        csr_wdata = 32'd0;
        csr_wmask = 32'd0;
        csr_rch   = 3'd0;
        csr_rreg  = 2'd0;
        cyc(3);
        reset = 1'b0;

        // Reset state
        for (int c = 0; c < 8; c++) begin
            for (int r = 0; r < 4; r++) begin
                rd("rst_rdata", 3'(c), 2'(r), 32'd0);
            end
        end
        chk("rst_irq", 32'(ti_irq), 32'd0);
        pend("rst_pend", 2'b00);
        chk("rst_cnt_lo", counter_lo, 32'd0);
        chk("rst_cnt_hi", counter_hi, 32'd0);
        cyc(100);
        chk("cnt_100", counter_lo, 32'd100);

        // ch0 one-shot, R=16
        wr(3'd0, TMR_TCFG, 32'h0000_0011, 32'hFFFF_FFFF);
        rd("c0_tcfg", 3'd0, TMR_TCFG, 32'h0000_0011);
        rd("c0_tval_load", 3'd0, TMR_TVAL, 32'd16);
        for (int k = 1; k <= 15; k++) begin
            cyc(1);
            rd("c0_tval_cnt", 3'd0, TMR_TVAL, 32'(16 - k));
            pend("c0_pend_early", 2'b00);
        end
        cyc(1);
        pend("c0_pend_fire", 2'b01);
        chk("c0_irq", 32'(ti_irq), 32'd1);
        rd("c0_tval_halt", 3'd0, TMR_TVAL, 32'd0);
        cyc(5);
        rd("c0_tval_stays", 3'd0, TMR_TVAL, 32'd0);
        pend("c0_pend_sticky", 2'b01);
        wr(3'd0, TMR_TICLR, 32'd1, 32'hFFFF_FFFF);
        pend("c0_ticlr", 2'b00);
        rd("c0_ticlr_rd", 3'd0, TMR_TICLR, 32'd0);

        // ch1 periodic, R=8
        wr(3'd1, TMR_TCFG, 32'h0000_000B, 32'hFFFF_FFFF);
        rd("c1_tcfg", 3'd1, TMR_TCFG, 32'h0000_000B);
        rd("c1_tval_load", 3'd1, TMR_TVAL, 32'd8);
        cyc(7);
        rd("c1_tval_one", 3'd1, TMR_TVAL, 32'd1);
        pend("c1_pend_early", 2'b00);
        cyc(1);
        pend("c1_pend_8", 2'b10);
        rd("c1_reload", 3'd1, TMR_TVAL, 32'd8);
        wr(3'd1, TMR_TICLR, 32'd1, 32'hFFFF_FFFF);
        pend("c1_clear", 2'b00);
        rd("c1_tval_7", 3'd1, TMR_TVAL, 32'd7);
        cyc(6);
        rd("c1_tval_one2", 3'd1, TMR_TVAL, 32'd1);
        pend("c1_pend_early2", 2'b00);
        cyc(1);
        pend("c1_pend_16", 2'b10);
        rd("c0_untouched_tval", 3'd0, TMR_TVAL, 32'd0);
        rd("c0_untouched_tcfg", 3'd0, TMR_TCFG, 32'h0000_0011);
        wr(3'd1, TMR_TCFG, 32'd0, 32'hFFFF_FFFF);
        pend("c1_tcfg_keeps_pend", 2'b10);
        rd("c1_off_tval", 3'd1, TMR_TVAL, 32'd0);
        wr(3'd1, TMR_TICLR, 32'd1, 32'd1);
        pend("c1_clear2", 2'b00);

        // TICLR in the exact expiry cycle of periodic ch0, R=4
        wr(3'd0, TMR_TCFG, 32'h0000_0007, 32'hFFFF_FFFF);
        rd("c0p_load", 3'd0, TMR_TVAL, 32'd4);
        cyc(3);
        rd("c0p_one", 3'd0, TMR_TVAL, 32'd1);
        pend("c0p_early", 2'b00);
        wr(3'd0, TMR_TICLR, 32'd1, 32'hFFFF_FFFF);
        pend("c0p_set_beats_clr", 2'b01);
        rd("c0p_reload", 3'd0, TMR_TVAL, 32'd4);
        wr(3'd0, TMR_TICLR, 32'd1, 32'd0);
        pend("c0p_mask0_noclr", 2'b01);

        // csrxchg clearing only En on running ch0
        wr(3'd0, TMR_TCFG, 32'd0, 32'h0000_0001);
        rd("xchg_tcfg", 3'd0, TMR_TCFG, 32'h0000_0006);
        rd("xchg_tval", 3'd0, TMR_TVAL, 32'd4);
        cyc(5);
        rd("xchg_frozen", 3'd0, TMR_TVAL, 32'd4);
        pend("xchg_pend_kept", 2'b01);

        // Out-of-range channel and reserved register
        wr(3'd5, TMR_TCFG, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int r = 0; r < 4; r++) begin
            rd("ch5_rd", 3'd5, 2'(r), 32'd0);
        end
        rd("ch5_no_c0", 3'd0, TMR_TCFG, 32'h0000_0006);
        rd("ch5_no_c1", 3'd1, TMR_TCFG, 32'd0);
        wr(3'd0, 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd("reg3_rd", 3'd0, 2'd3, 32'd0);
        rd("reg3_no_tcfg", 3'd0, TMR_TCFG, 32'h0000_0006);
        rd("reg3_no_tval", 3'd0, TMR_TVAL, 32'd4);
        wr(3'd5, TMR_TICLR, 32'd1, 32'hFFFF_FFFF);
        pend("ch5_ticlr_noeffect", 2'b01);
        wr(3'd0, TMR_TICLR, 32'd1, 32'hFFFF_FFFF);
        pend("c0_clear_final", 2'b00);
        chk("irq_low", 32'(ti_irq), 32'd0);

        // Zero reload value never fires
        wr(3'd0, TMR_TCFG, 32'h0000_0003, 32'hFFFF_FFFF);
        rd("r0_tval", 3'd0, TMR_TVAL, 32'd0);
        cyc(10);
        pend("r0_no_pend", 2'b00);
        rd("r0_tval_stay", 3'd0, TMR_TVAL, 32'd0);

        // Reset mid-count with a pending interrupt
        wr(3'd1, TMR_TCFG, 32'h0000_000B, 32'hFFFF_FFFF);
        cyc(8);
        pend("pre_rst_pend", 2'b10);
        cyc(3);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        pend("mid_rst_pend", 2'b00);
        chk("mid_rst_irq", 32'(ti_irq), 32'd0);
        chk("mid_rst_cnt_lo", counter_lo, 32'd0);
        chk("mid_rst_cnt_hi", counter_hi, 32'd0);
        rd("mid_rst_c0_tcfg", 3'd0, TMR_TCFG, 32'd0);
        rd("mid_rst_c1_tcfg", 3'd1, TMR_TCFG, 32'd0);
        rd("mid_rst_c1_tval", 3'd1, TMR_TVAL, 32'd0);
        cyc(5);
        rd("mid_rst_c1_idle", 3'd1, TMR_TVAL, 32'd0);
        chk("cnt_5", counter_lo, 32'd5);

        // Stable counter wrap at CNT_W=34
        force dut.cnt_r = 34'h3_FFFF_FFFF;
        #1;
        chk("wrap_pre_hi", counter_hi, 32'h0000_0003);
        chk("wrap_pre_lo", counter_lo, 32'hFFFF_FFFF);
        release dut.cnt_r;
        cyc(1);
        chk("wrap_hi", counter_hi, 32'd0);
        chk("wrap_lo", counter_lo, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
